hazard_forward_unit: RTL and testbench

- Parametrised hazard detection and forwarding controller for the 5-stage MIPS pipeline.
- Drives hazard, flushId, forwardingMux0Ex and forwardingMux1Ex, which are currently tied off at top level.
- Adds branch-in-ID operand stalls and a multi-cycle data-memory freeze (memStall) sequenced by a small FSM and counter.
- Sits beside the stages; reads the addresses and control bits held in the pipeline registers.

---
 rtl/hazard_forward_unit_if.sv | 57 +++++
 rtl/hazard_forward_unit.sv | 139 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// +----------------------------------------------------------------------+
// | hazard_forward_unit_if : pipeline-register view used by the hazard   |
// | and forwarding controller.        Rev 1.0                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] addressRsId;
  logic [REG_ADDR_W-1:0] addressRtId;
  logic                  usesRsId;
  logic                  usesRtId;
  logic                  branchRegsId;
  logic                  branchControlId;
  logic                  jumpId;
  logic [REG_ADDR_W-1:0] addressRsEx;
  logic [REG_ADDR_W-1:0] addressRtEx;
  logic                  memReadEx;
  logic                  regWriteEx;
  logic [REG_ADDR_W-1:0] regWriteRegisterEx;
  logic                  memReadMemInput;
  logic                  memWriteMemInput;
  logic                  regWriteMemInput;
  logic [REG_ADDR_W-1:0] regWriteRegisterMemInput;
  logic                  regWriteWbInput;
  logic [REG_ADDR_W-1:0] regWriteAddressWbInput;
  logic                  hazard;
  logic                  flushId;
  logic                  memStall;
  logic [1:0]            forwardingMux0Ex;
  logic [1:0]            forwardingMux1Ex;
  logic [31:0]           stallCycleCount;
  logic [31:0]           flushCount;

  modport master (
    output addressRsId, addressRtId, usesRsId, usesRtId, branchRegsId,
           branchControlId, jumpId, addressRsEx, addressRtEx, memReadEx,
           regWriteEx, regWriteRegisterEx, memReadMemInput, memWriteMemInput,
           regWriteMemInput, regWriteRegisterMemInput, regWriteWbInput,
           regWriteAddressWbInput,
    input  hazard, flushId, memStall, forwardingMux0Ex, forwardingMux1Ex,
           stallCycleCount, flushCount
  );

  modport slave (
    input  addressRsId, addressRtId, usesRsId, usesRtId, branchRegsId,
           branchControlId, jumpId, addressRsEx, addressRtEx, memReadEx,
           regWriteEx, regWriteRegisterEx, memReadMemInput, memWriteMemInput,
           regWriteMemInput, regWriteRegisterMemInput, regWriteWbInput,
           regWriteAddressWbInput,
    output hazard, flushId, memStall, forwardingMux0Ex, forwardingMux1Ex,
           stallCycleCount, flushCount
  );
endinterface

`default_nettype wire

// File: rtl/hazard_forward_unit.sv
// +----------------------------------------------------------------------+
// | hazard_forward_unit : forwarding selects, load-use/branch stalls and |
// | multi-cycle MEM freeze. Optional counters: HAZARD_STATS_EN. Rev 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_forward_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_forward_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } mem_state_t;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             access;
  logic             mem_stall;
  logic             load_use;
  logic             branch_dep;
  logic             hazard_w;
  logic             flush_w;
  logic [1:0]       fwd0;
  logic [1:0]       fwd1;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  mem_we,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd
  );
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) return 2'b10;
    if (wb_we && (wb_rd != '0) && (wb_rd == src)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    fwd0 = fwd_sel(bus.addressRsEx, bus.regWriteMemInput, bus.regWriteRegisterMemInput,
                   bus.regWriteWbInput, bus.regWriteAddressWbInput);
    fwd1 = fwd_sel(bus.addressRtEx, bus.regWriteMemInput, bus.regWriteRegisterMemInput,
                   bus.regWriteWbInput, bus.regWriteAddressWbInput);
  end

  always_comb begin
    load_use = bus.memReadEx && (bus.regWriteRegisterEx != '0) &&
               ((bus.usesRsId && (bus.regWriteRegisterEx == bus.addressRsId)) ||
                (bus.usesRtId && (bus.regWriteRegisterEx == bus.addressRtId)));
    branch_dep = bus.branchRegsId && (
      (bus.regWriteEx && (bus.regWriteRegisterEx != '0) &&
       ((bus.regWriteRegisterEx == bus.addressRsId) ||
        (bus.regWriteRegisterEx == bus.addressRtId))) ||
      (bus.memReadMemInput && (bus.regWriteRegisterMemInput != '0) &&
       ((bus.regWriteRegisterMemInput == bus.addressRsId) ||
        (bus.regWriteRegisterMemInput == bus.addressRtId))));
  end

  // RELEASE always returns to IDLE so a frozen access is not re-counted.
  always_comb begin
    access    = bus.memReadMemInput || bus.memWriteMemInput;
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((MEM_LATENCY > 1) && access) begin
          mem_stall = 1'b1;
          cnt_d     = CNT_W'(MEM_LATENCY - 2);
          state_d   = (MEM_LATENCY > 2) ? ST_WAIT : ST_RELEASE;
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    hazard_w = reset && (load_use || branch_dep) && !mem_stall;
    flush_w  = reset && (bus.branchControlId || bus.jumpId) && !hazard_w && !mem_stall;
  end

  assign bus.hazard           = hazard_w;
  assign bus.flushId          = flush_w;
  assign bus.memStall         = reset && mem_stall;
  assign bus.forwardingMux0Ex = reset ? fwd0 : 2'b00;
  assign bus.forwardingMux1Ex = reset ? fwd1 : 2'b00;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycle_count_q, stall_cycle_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycle_count_d = stall_cycle_count_q + {31'd0, (hazard_w || bus.memStall)};
    flush_count_d       = flush_count_q + {31'd0, flush_w};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycle_count_q <= 32'd0;
      flush_count_q       <= 32'd0;
    end else begin
      stall_cycle_count_q <= stall_cycle_count_d;
      flush_count_q       <= flush_count_d;
    end
  end

  assign bus.stallCycleCount = stall_cycle_count_q;
  assign bus.flushCount      = flush_count_q;
`else
  assign bus.stallCycleCount = 32'd0;
  assign bus.flushCount      = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
// +----------------------------------------------------------------------+
// | tb_hazard_forward_unit : directed bench with a per-cycle reference   |
// | model for hazard_forward_unit (MEM_LATENCY = 4).   Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hazard_forward_unit;
  localparam int AW  = 5;
  localparam int LAT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  hazard_forward_unit_if #(.REG_ADDR_W(AW)) bus();

  hazard_forward_unit #(.REG_ADDR_W(AW), .MEM_LATENCY(LAT), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.addressRsId = '0; bus.addressRtId = '0; bus.usesRsId = 0; bus.usesRtId = 0;
    bus.branchRegsId = 0; bus.branchControlId = 0; bus.jumpId = 0;
    bus.addressRsEx = '0; bus.addressRtEx = '0; bus.memReadEx = 0; bus.regWriteEx = 0;
    bus.regWriteRegisterEx = '0; bus.memReadMemInput = 0; bus.memWriteMemInput = 0;
    bus.regWriteMemInput = 0; bus.regWriteRegisterMemInput = '0;
    bus.regWriteWbInput = 0; bus.regWriteAddressWbInput = '0;
  endtask

  // Reference model: remaining-stall-cycle count plus a one-cycle release flag.
  int          busy     = 0;
  bit          rel      = 1'b0;
  logic [31:0] m_stalls = 32'd0;
  logic [31:0] m_flush  = 32'd0;

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] x);
    if (bus.regWriteMemInput && bus.regWriteRegisterMemInput != 0 &&
        bus.regWriteRegisterMemInput == x) return 2'b10;
    if (bus.regWriteWbInput && bus.regWriteAddressWbInput != 0 &&
        bus.regWriteAddressWbInput == x) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_dep(input bit en, input logic [AW-1:0] d, input bit both);
    if (!en || d == 0) return 0;
    if (both) return (d == bus.addressRsId) || (d == bus.addressRtId);
    return (bus.usesRsId && d == bus.addressRsId) || (bus.usesRtId && d == bus.addressRtId);
  endfunction

  always @(negedge clk) begin : cmp
    bit e_stall, e_haz, e_flush, acc;
    if (!reset) begin
      check("rst_hazard", bus.hazard, 0);
      check("rst_flush", bus.flushId, 0);
      check("rst_stall", bus.memStall, 0);
      check("rst_fwd0", bus.forwardingMux0Ex, 0);
      check("rst_fwd1", bus.forwardingMux1Ex, 0);
      check("rst_stallcnt", bus.stallCycleCount, 0);
      check("rst_flushcnt", bus.flushCount, 0);
      busy = 0; rel = 0; m_stalls = 0; m_flush = 0;
    end else begin
      acc     = bus.memReadMemInput || bus.memWriteMemInput;
      e_stall = (busy > 0) || (!rel && acc && LAT > 1);
      e_haz   = (m_dep(bus.memReadEx, bus.regWriteRegisterEx, 0) ||
                 (bus.branchRegsId && (m_dep(bus.regWriteEx, bus.regWriteRegisterEx, 1) ||
                  m_dep(bus.memReadMemInput, bus.regWriteRegisterMemInput, 1)))) && !e_stall;
      e_flush = (bus.branchControlId || bus.jumpId) && !e_haz && !e_stall;
      check("m_hazard", bus.hazard, e_haz);
      check("m_flush", bus.flushId, e_flush);
      check("m_stall", bus.memStall, e_stall);
      check("m_fwd0", bus.forwardingMux0Ex, m_fwd(bus.addressRsEx));
      check("m_fwd1", bus.forwardingMux1Ex, m_fwd(bus.addressRtEx));
`ifdef HAZARD_STATS_EN
      check("m_stallcnt", bus.stallCycleCount, m_stalls);
      check("m_flushcnt", bus.flushCount, m_flush);
`else
      check("m_stallcnt", bus.stallCycleCount, 0);
      check("m_flushcnt", bus.flushCount, 0);
`endif
      if (e_stall) begin
        if (busy == 0) busy = LAT - 1;
        busy--;
        rel = (busy == 0);
      end else begin
        rel = 0;
      end
      if (e_haz || e_stall) m_stalls++;
      if (e_flush) m_flush++;
    end
  end

  logic [7:0] b2b_stall = 8'b0111_0111;
  logic [3:0] rst_stall = 4'b0111;
  logic [31:0] exp_stats;

  initial begin
    clear();
    // Inputs that would forward/stall/flush, held while in reset.
    bus.regWriteMemInput = 1; bus.regWriteRegisterMemInput = 3; bus.addressRsEx = 3;
    bus.memReadMemInput = 1; bus.memReadEx = 1; bus.regWriteRegisterEx = 5;
    bus.addressRtId = 5; bus.usesRtId = 1; bus.jumpId = 1;
    tick(); #1;
    check("lit_rst_fwd0", bus.forwardingMux0Ex, 2'b00);
    check("lit_rst_hazard", bus.hazard, 0);
    check("lit_rst_stall", bus.memStall, 0);
    tick(); clear(); reset = 1;

    // Forwarding priority and r0 exclusion.
    tick(); bus.addressRsEx = 3; bus.regWriteMemInput = 1; bus.regWriteRegisterMemInput = 3;
    bus.regWriteWbInput = 1; bus.regWriteAddressWbInput = 3;
    #1 check("lit_fwd_mem_beats_wb", bus.forwardingMux0Ex, 2'b10);
    tick(); bus.regWriteMemInput = 0;
    #1 check("lit_fwd_wb", bus.forwardingMux0Ex, 2'b01);
    tick(); bus.regWriteMemInput = 1; bus.regWriteRegisterMemInput = 0;
    bus.regWriteAddressWbInput = 0; bus.addressRsEx = 0;
    #1 check("lit_fwd_r0", bus.forwardingMux0Ex, 2'b00);
    tick(); clear(); bus.addressRtEx = 9; bus.regWriteMemInput = 1;
    bus.regWriteRegisterMemInput = 8; bus.regWriteWbInput = 1; bus.regWriteAddressWbInput = 9;
    #1 check("lit_fwd1_wb", bus.forwardingMux1Ex, 2'b01);

    // Matching register not actually read: no stall.
    tick(); clear(); bus.memReadEx = 1; bus.regWriteEx = 1; bus.regWriteRegisterEx = 5;
    bus.addressRtId = 5; bus.usesRtId = 0;
    #1 check("lit_lu_unused", bus.hazard, 0);

    // Load-use, then the load freezes MEM for LAT-1 cycles, then WB forwards.
    tick(); bus.usesRtId = 1;
    #1 check("lit_lu_hazard", bus.hazard, 1);
    tick(); bus.memReadEx = 0; bus.regWriteEx = 0; bus.regWriteRegisterEx = 0;
    bus.memReadMemInput = 1; bus.regWriteMemInput = 1; bus.regWriteRegisterMemInput = 5;
    #1 check("lit_lu_bubble", bus.hazard, 0);
    check("lit_lu_stall0", bus.memStall, 1);
    tick(); #1 check("lit_lu_stall1", bus.memStall, 1);
    tick(); #1 check("lit_lu_stall2", bus.memStall, 1);
    tick(); #1 check("lit_lu_release", bus.memStall, 0);
    tick(); clear(); bus.regWriteWbInput = 1; bus.regWriteAddressWbInput = 5; bus.addressRtEx = 5;
    #1 check("lit_lu_wb_fwd", bus.forwardingMux1Ex, 2'b01);
`ifdef HAZARD_STATS_EN
    exp_stats = 32'd4;
`else
    exp_stats = 32'd0;
`endif
    check("lit_stallcnt_4", bus.stallCycleCount, exp_stats);

    // Branch waiting on an EX producer, then flushing once it sits in MEM.
    tick(); clear(); bus.branchRegsId = 1; bus.addressRsId = 7; bus.usesRsId = 1;
    bus.branchControlId = 1; bus.regWriteEx = 1; bus.regWriteRegisterEx = 7;
    #1 check("lit_br_hazard", bus.hazard, 1);
    check("lit_br_noflush", bus.flushId, 0);
    tick(); bus.regWriteEx = 0; bus.regWriteRegisterEx = 0;
    bus.regWriteMemInput = 1; bus.regWriteRegisterMemInput = 7;
    #1 check("lit_br_resolved", bus.hazard, 0);
    check("lit_br_flush", bus.flushId, 1);

    // Back-to-back stores with a load-use masked by the freeze.
    tick(); clear(); bus.memWriteMemInput = 1; bus.memReadEx = 1; bus.regWriteEx = 1;
    bus.regWriteRegisterEx = 6; bus.addressRsId = 6; bus.usesRsId = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("lit_b2b_stall", bus.memStall, b2b_stall[i]);
      check("lit_b2b_hazard", bus.hazard, !b2b_stall[i]);
      tick();
    end

    // Asynchronous reset in WAIT with cnt == 1.
    clear();
    tick(); bus.memReadMemInput = 1;
    tick(); tick();
    reset = 0;
    #1 check("lit_async_rst_stall", bus.memStall, 0);
    check("lit_async_rst_cnt", bus.stallCycleCount, 0);
    tick(); tick(); reset = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check("lit_post_rst_stall", bus.memStall, rst_stall[i]);
      tick();
    end

    // One taken jump after reset.
    clear(); bus.jumpId = 1;
    #1 check("lit_jump_flush", bus.flushId, 1);
    tick(); clear();
`ifdef HAZARD_STATS_EN
    exp_stats = 32'd1;
`else
    exp_stats = 32'd0;
`endif
    #1 check("lit_flushcnt_1", bus.flushCount, exp_stats);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
